vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator, the next generation of the fixed 640x480 VGA_Controller in the scanner display path. It produces sync, blanking and RGB for any resolution and sync polarity. It issues pixel requests a configurable number of ticks ahead of display, so the SDRAM read FIFO latency is absorbed without a patch in vga_top. It also drives frame and line fetch strobes for sdram_top (RD/RDR), accepts a pixel-clock enable, and has built-in test-pattern modes for bring-up without SDRAM.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of oVGA_H_SYNC
- VS_POL, 0, active level of oVGA_V_SYNC
- REQ_LEAD, 2, ticks by which the request precedes display; legal range 1..H_FP+H_SYNC+H_BP-1
- CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- iCLK  in  1  clock
- iRST  in  1  reset, asynchronous, active-high
- iEN  in  1  pixel tick enable; counters advance only when high
- iMODE  in  2  00 pass-through, 01 colour bars, 10 grid, 11 black
- iRed, iGreen, iBlue  in  8 each  pixel data from source
- oVGA_R, oVGA_G, oVGA_B  out  8 each  registered video
- oVGA_H_SYNC, oVGA_V_SYNC  out  1  syncs
- oVGA_BLANK_N  out  1  high during active video
- oRequest  out  1  pixel request (pass-through mode only)
- oX, oY  out  CW  coordinate of the pixel being requested
- oFrameSync  out  1  one-clock pulse per frame (to RD)
- oLineSync  out  1  one-clock pulse per active line (to RDR)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Display counters h, v:
  - h counts 0..H_TOTAL-1 on each tick and wraps to 0.
  - v increments when h wraps, and wraps at V_TOTAL.
  - Active region: h<H_ACTIVE and v<V_ACTIVE.
- Request counters rh, rv: same wrap rules, kept exactly REQ_LEAD ticks ahead of (h,v) in raster order.
- Reset values (asynchronous):
  - Counters: h=0, v=V_ACTIVE, rh=REQ_LEAD, rv=V_ACTIVE.
  - Mode register: 00.
  - Outputs: RGB 0; oVGA_H_SYNC=~HS_POL; oVGA_V_SYNC=~VS_POL; BLANK_N, oRequest, oFrameSync, oLineSync all 0; oX and oY 0.
- HS active while h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. VS active while v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; VS changes only at h=0.
- oRequest=1 when mode=00, rh<H_ACTIVE and rv<V_ACTIVE. oX=rh and oY=rv are registered alongside it.
- Source contract: data for the request issued on tick t must be valid on iRed/iGreen/iBlue during tick t+REQ_LEAD, which is the tick on which (h,v) equals that pixel.
- RGB register loads on every tick:
  - Outside the active region: 0.
  - Mode 00: iRGB.
  - Mode 01: 8 bars of H_ACTIVE/8 ticks each, in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 (R,G,B); the last bar extends to H_ACTIVE.
  - Mode 10: FFFFFF where h[3:0]==0 or v[3:0]==0, else 000000.
  - Mode 11: 0.
- iMODE is sampled only on the tick where h=0 and v=0. A mid-frame change takes effect at the next frame.
- oFrameSync: pulses on the tick where h=0 and v=V_ACTIVE+V_FP (start of vertical sync).
- oLineSync: pulses on the tick where rh=H_ACTIVE and rv<V_ACTIVE, i.e. the end of each line's fetch window.

## Timing
- Every output is registered: a value computed from the counter state during tick n appears after the clock edge that ends tick n. Sync, blank and RGB stay mutually aligned.
- With iEN=0, counters and all level outputs hold. oFrameSync and oLineSync are asserted for exactly one iCLK, only on an iEN=1 edge, and return to 0 on the next edge.
- With iEN=1 every clock and default parameters:
  - HS period 800 clocks, active 96.
  - VS period 420000 clocks, active 1600.
  - BLANK_N high for 640 consecutive clocks on each of 480 lines.
- Simultaneous events: the frame-start iMODE sample and a request wrap on the same tick cause no conflict; requests already issued in the old mode are not cancelled.
- Reset mid-operation: outputs take reset values immediately. After release, BLANK_N stays 0 until v wraps to 0. The first oFrameSync comes V_FP lines after release, the first active pixel V_TOTAL-V_ACTIVE lines after release.

## Test plan
- Default params, iEN=1, mode 00, reset then run 2 frames -> HS period 800 and low 96; VS period 420000 and low 1600; 480 BLANK_N windows of 640 clocks per frame.
- REQ_LEAD=2 with a source model returning {oX[7:0]} exactly 2 ticks after each request -> displayed pixel x has oVGA_R = x[7:0] for every x; 307200 requests per frame; no request outside active lines.
- iMODE=01 applied at v=100 -> the current frame stays pass-through; the next frame shows bars 80 pixels wide (pixel 0 FFFFFF, pixel 80 FFFF00, pixel 639 000000); oRequest stays 0 for that frame.
- iEN toggled 1,0,1,0 -> HS low for 192 clocks; oFrameSync and oLineSync each exactly 1 clock wide, 480 oLineSync pulses per frame.
- iRST pulsed at h=300, v=100 -> all outputs equal their reset values within the same clock; first oFrameSync after release arrives exactly 10 lines (8000 clocks) later.
- HS_POL=1, VS_POL=1, H=8/2/2/2, V=4/1/1/1 -> HS high at h=10..11 of every 14-clock line; VS high during line 5 of each 7-line frame; BLANK_N high at h=0..7 on v=0..3.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing with look-ahead pixel requests,
//            fetch strobes, registered video and built-in test patterns.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 2,
  parameter int CW       = 10
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iEN,
  input  logic [1:0]    iMODE,
  input  logic [7:0]    iRed,
  input  logic [7:0]    iGreen,
  input  logic [7:0]    iBlue,
  output logic [7:0]    oVGA_R,
  output logic [7:0]    oVGA_G,
  output logic [7:0]    oVGA_B,
  output logic          oVGA_H_SYNC,
  output logic          oVGA_V_SYNC,
  output logic          oVGA_BLANK_N,
  output logic          oRequest,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oFrameSync,
  output logic          oLineSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] c_H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] c_H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] c_RH_RST   = CW'(REQ_LEAD);

  logic [CW-1:0] h_q, v_q, rh_q, rv_q, h_d, v_d, rh_d, rv_d;
  logic [1:0]    mode_q, mode_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic          req_q, req_d, fs_q, fs_d, ls_q, ls_d;
  logic [CW-1:0] x_q, y_q;
  logic          active;
  logic [2:0]    bar_idx;

  always_comb begin
    h_d       = h_q + 1'b1;
    v_d       = v_q;
    rh_d      = rh_q + 1'b1;
    rv_d      = rv_q;
    mode_d    = mode_q;
    rgb_d     = 24'h000000;
    bar_idx   = 3'd0;
    active    = (h_q < c_H_ACT) && (v_q < c_V_ACT);

    if (h_q == c_H_LAST) begin
      h_d = '0;
      v_d = (v_q == c_V_LAST) ? '0 : v_q + 1'b1;
    end
    if (rh_q == c_H_LAST) begin
      rh_d = '0;
      rv_d = (rv_q == c_V_LAST) ? '0 : rv_q + 1'b1;
    end

    // The frame-start pixel already uses the newly sampled mode.
    if ((h_q == '0) && (v_q == '0)) mode_d = iMODE;

    for (int k = 1; k < 8; k++) begin
      if (h_q >= CW'(k * (H_ACTIVE / 8))) bar_idx = 3'(k);
    end

    if (active) begin
      case (mode_d)
        2'b00:   rgb_d = {iRed, iGreen, iBlue};
        2'b01:   rgb_d = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
        2'b10:   rgb_d = ((h_q[3:0] == 4'd0) || (v_q[3:0] == 4'd0)) ? 24'hFFFFFF : 24'h000000;
        default: rgb_d = 24'h000000;
      endcase
    end

    hs_d      = ((h_q >= c_HS_START) && (h_q < c_HS_END)) ? HS_POL : ~HS_POL;
    vs_d      = ((v_q >= c_VS_START) && (v_q < c_VS_END)) ? VS_POL : ~VS_POL;
    blank_n_d = active;
    req_d     = (mode_d == 2'b00) && (rh_q < c_H_ACT) && (rv_q < c_V_ACT);
    fs_d      = (h_q == '0) && (v_q == c_VS_START);
    ls_d      = (rh_q == c_H_ACT) && (rv_q < c_V_ACT);
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      h_q       <= '0;
      v_q       <= c_V_ACT;
      rh_q      <= c_RH_RST;
      rv_q      <= c_V_ACT;
      mode_q    <= 2'b00;
      rgb_q     <= 24'h000000;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
      req_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      // Strobes are single-clock even when iEN stays low afterwards.
      fs_q <= iEN & fs_d;
      ls_q <= iEN & ls_d;
      if (iEN) begin
        h_q       <= h_d;
        v_q       <= v_d;
        rh_q      <= rh_d;
        rv_q      <= rv_d;
        mode_q    <= mode_d;
        rgb_q     <= rgb_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        blank_n_q <= blank_n_d;
        req_q     <= req_d;
        x_q       <= rh_q;
        y_q       <= rv_q;
      end
    end
  end

  assign {oVGA_R, oVGA_G, oVGA_B} = rgb_q;
  assign oVGA_H_SYNC  = hs_q;
  assign oVGA_V_SYNC  = vs_q;
  assign oVGA_BLANK_N = blank_n_q;
  assign oRequest     = req_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oFrameSync   = fs_q;
  assign oLineSync    = ls_q;

endmodule
`default_nettype wire
